// File: rtl/mem_copy_engine.sv
// mem_copy_engine: forward block-copy master for a single-port byte memory, one byte per two clocks.
// Build option MEMCPY_CSUM_EN adds a running modulo-2^DW checksum of the copied bytes on port csum.
module mem_copy_engine #(
  parameter int AW = 8,
  parameter int DW = 8
) (
  input  logic          CLK,
  input  logic          reset,
  input  logic          start,
  input  logic [AW-1:0] src,
  input  logic [AW-1:0] dst,
  input  logic [AW:0]   len,
  output logic          busy,
  output logic          done,
  output logic [AW:0]   count,
  output logic [AW-1:0] mem_addr,
  output logic          mem_rd,
  output logic          mem_wr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
`ifdef MEMCPY_CSUM_EN
  ,
  output logic [DW-1:0] csum
`endif
);

  // state | meaning
  // IDLE  | port released to core, waiting for start
  // READ  | reading byte src+count into hold
  // WRITE | writing hold to dst+count, advancing count
  // DONE  | one-cycle completion pulse
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] src_q, src_d;
  logic [AW-1:0] dst_q, dst_d;
  logic [AW:0]   len_q, len_d;
  logic [AW:0]   count_q, count_d;
  logic [DW-1:0] hold_q, hold_d;
  logic [AW:0]   count_inc;
`ifdef MEMCPY_CSUM_EN
  logic [DW-1:0] csum_q, csum_d;
`endif

  assign count_inc = count_q + {{AW{1'b0}}, 1'b1};

  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    len_d   = len_q;
    count_d = count_q;
    hold_d  = hold_q;
`ifdef MEMCPY_CSUM_EN
    csum_d  = csum_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          src_d   = src;
          dst_d   = dst;
          len_d   = len;
          count_d = '0;
`ifdef MEMCPY_CSUM_EN
          csum_d  = '0;
`endif
          state_d = (len == '0) ? S_DONE : S_READ;
        end
      end
      S_READ: begin
        hold_d  = mem_rdata;
        state_d = S_WRITE;
      end
      S_WRITE: begin
        count_d = count_inc;
`ifdef MEMCPY_CSUM_EN
        csum_d  = csum_q + hold_q;
`endif
        state_d = (count_inc == len_q) ? S_DONE : S_READ;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Port outputs depend only on registered state, never on start.
  always_comb begin
    busy      = 1'b0;
    done      = 1'b0;
    mem_addr  = '0;
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    mem_wdata = '0;
    case (state_q)
      S_READ: begin
        busy     = 1'b1;
        mem_rd   = 1'b1;
        mem_addr = src_q + count_q[AW-1:0];
      end
      S_WRITE: begin
        busy      = 1'b1;
        mem_wr    = 1'b1;
        mem_addr  = dst_q + count_q[AW-1:0];
        mem_wdata = hold_q;
      end
      S_DONE: begin
        done = 1'b1;
      end
      default: begin
      end
    endcase
  end

  assign count = count_q;
`ifdef MEMCPY_CSUM_EN
  assign csum  = csum_q;
`endif

  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q <= S_IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      len_q   <= '0;
      count_q <= '0;
      hold_q  <= '0;
`ifdef MEMCPY_CSUM_EN
      csum_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      len_q   <= len_d;
      count_q <= count_d;
      hold_q  <= hold_d;
`ifdef MEMCPY_CSUM_EN
      csum_q  <= csum_d;
`endif
    end
  end

endmodule
